// File: rtl/out_port_arbiter_pkg.sv
// Shared widths, flit-type codes and index helpers for the output-port arbiter.
// Latency: none (constants and pure functions only).
// Backpressure: none (no datapath in this file).
package out_port_arbiter_pkg;

  localparam int NCH      = 5;   // input channels per router
  localparam int DATAW    = 31;  // flit MSB index (flit is DATAW+1 bits)
  localparam int VCHW     = 1;   // VC tag MSB index
  localparam int PORTW    = 2;   // port number MSB index
  localparam int TYPE_MSB = 31;  // flit type field position inside a flit
  localparam int TYPE_LSB = 29;

  localparam logic [2:0] TYPE_NONE     = 3'd0;
  localparam logic [2:0] TYPE_HEAD     = 3'd1;
  localparam logic [2:0] TYPE_BODY     = 3'd2;
  localparam logic [2:0] TYPE_TAIL     = 3'd3;
  localparam logic [2:0] TYPE_HEADTAIL = 3'd4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // Channel indices live in 0..4; any stray 5..7 is folded back to 0.
  function automatic logic [2:0] idx_fix(input logic [2:0] v);
    return (v > 3'd4) ? 3'd0 : v;
  endfunction

  // Round-robin successor of a channel index (4 wraps to 0).
  function automatic logic [2:0] idx_next(input logic [2:0] v);
    logic [2:0] f;
    f = idx_fix(v);
    return (f == 3'd4) ? 3'd0 : f + 3'd1;
  endfunction

endpackage

// File: rtl/out_port_arbiter_rr_pick.sv
// Combinational 5-way round-robin picker: first set request at or after ptr.
// Latency: purely combinational, zero cycles.
// Backpressure: none; valid_o simply reports whether any request is present.
module out_port_arbiter_rr_pick
  import out_port_arbiter_pkg::*;
(
  input  logic [NCH-1:0] r_i,
  input  logic [2:0]     ptr_i,
  output logic           valid_o,
  output logic [2:0]     idx_o
);

  logic [2:0] start;
  logic [3:0] sum;
  logic [2:0] cand;

  // Scan from lowest to highest priority so the last hit (closest to ptr) wins.
  always_comb begin
    start   = idx_fix(ptr_i);
    valid_o = |r_i;
    idx_o   = 3'd0;
    sum     = 4'd0;
    cand    = 3'd0;
    for (int k = NCH - 1; k >= 0; k--) begin
      sum  = {1'b0, start} + 4'(k);
      cand = (sum >= 4'(NCH)) ? 3'(sum - 4'(NCH)) : sum[2:0];
      if (r_i[cand]) idx_o = cand;
    end
  end

endmodule

// File: rtl/out_port_arbiter.sv
// Output-port switch allocator: round-robin grant held per packet, one output register stage.
// Latency: request->grant 1 clk; owner flit->ovalid/odata 1 clk; tail releases on the same edge.
// Backpressure: none on the link; non-owner flits are dropped and losers wait for the next round.
module out_port_arbiter
  import out_port_arbiter_pkg::*;
#(
  parameter int PORTID = 0
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic [NCH-1:0]            req_i,
  input  logic [NCH-1:0][PORTW:0]   port_i,
  input  logic [NCH-1:0][DATAW:0]   idata_i,
  input  logic [NCH-1:0]            ivalid_i,
  input  logic [NCH-1:0][VCHW:0]    ivch_i,
  output logic [NCH-1:0]            grt_i,
  output logic [DATAW:0]            odata,
  output logic                      ovalid,
  output logic [VCHW:0]             ovch,
  output logic                      busy
);

  localparam logic [PORTW:0] PID = PORTID[PORTW:0];

  state_e         state_q, state_d;
  logic [2:0]     owner_q, owner_d;
  logic [2:0]     ptr_q, ptr_d;
  logic [DATAW:0] odata_q;
  logic           ovalid_q;
  logic [VCHW:0]  ovch_q;

  logic [NCH-1:0] r_eff;
  logic           pick_vld;
  logic [2:0]     pick_idx;
  logic [2:0]     owner_s;
  logic           own_vld;
  logic [DATAW:0] own_dat;
  logic [VCHW:0]  own_vch;
  logic [2:0]     own_type;
  logic           own_tail;
  logic           fwd;

  // Only requests aimed at this output port take part in arbitration.
  always_comb begin
    r_eff = '0;
    for (int i = 0; i < NCH; i++) begin
      r_eff[i] = req_i[i] && (port_i[i] == PID);
    end
  end

  out_port_arbiter_rr_pick u_pick (
    .r_i     (r_eff),
    .ptr_i   (ptr_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  // Owner-selected view of the input channels.
  assign owner_s  = idx_fix(owner_q);
  assign own_vld  = ivalid_i[owner_s];
  assign own_dat  = idata_i[owner_s];
  assign own_vch  = ivch_i[owner_s];
  assign own_type = own_dat[TYPE_MSB:TYPE_LSB];
  assign own_tail = (own_type == TYPE_TAIL) || (own_type == TYPE_HEADTAIL);

  // Next state: grab a winner when idle, release on the owner's tail flit.
  always_comb begin
    state_d = state_q;
    owner_d = owner_s;
    ptr_d   = idx_fix(ptr_q);
    fwd     = 1'b0;
    if (state_q == ST_IDLE) begin
      if (pick_vld) begin
        state_d = ST_LOCKED;
        owner_d = pick_idx;
      end
    end else begin
      fwd = own_vld && (own_type != TYPE_NONE);
      if (own_vld && own_tail) begin
        state_d = ST_IDLE;
        ptr_d   = idx_next(owner_s);
      end
    end
  end

  // State and output registers; reset drops any packet in flight.
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q  <= ST_IDLE;
      owner_q  <= 3'd0;
      ptr_q    <= 3'd0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ovch_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      ovalid_q <= fwd;
      odata_q  <= fwd ? own_dat : '0;
      ovch_q   <= fwd ? own_vch : '0;
    end
  end

  assign grt_i  = (state_q == ST_LOCKED) ? (NCH'(1) << owner_s) : '0;
  assign busy   = (state_q == ST_LOCKED);
  assign odata  = odata_q;
  assign ovalid = ovalid_q;
  assign ovch   = ovch_q;

endmodule

// File: tb/tb_out_port_arbiter.sv
// Randomised plus directed bench with a queue-based scoreboard and a reference model.
// Latency: expectations are queued one cycle ahead of the outputs they describe.
// Backpressure: none; the monitor pops one status entry per cycle and one flit per ovalid.
module tb_out_port_arbiter;
  import out_port_arbiter_pkg::*;

  localparam int PID = 2;
  localparam int TW  = TYPE_MSB - TYPE_LSB + 1;

  logic                    clk = 1'b0;
  logic                    rst_;
  logic [NCH-1:0]          req;
  logic [NCH-1:0][PORTW:0] port;
  logic [NCH-1:0][DATAW:0] idata;
  logic [NCH-1:0]          ivalid;
  logic [NCH-1:0][VCHW:0]  ivch;
  logic [NCH-1:0]          grt;
  logic [DATAW:0]          odata;
  logic                    ovalid;
  logic [VCHW:0]           ovch;
  logic                    busy;

  always #5 clk = ~clk;

  out_port_arbiter #(.PORTID(PID)) dut (
    .clk      (clk),
    .rst_     (rst_),
    .req_i    (req),
    .port_i   (port),
    .idata_i  (idata),
    .ivalid_i (ivalid),
    .ivch_i   (ivch),
    .grt_i    (grt),
    .odata    (odata),
    .ovalid   (ovalid),
    .ovch     (ovch),
    .busy     (busy)
  );

  typedef struct packed {
    logic [NCH-1:0] grt;
    logic           busy;
    logic           ovalid;
  } st_t;

  typedef struct packed {
    logic [DATAW:0] dat;
    logic [VCHW:0]  vch;
  } fl_t;

  st_t sq[$];
  fl_t fq[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  g_log[$];
  logic [NCH-1:0] grt_prev = '0;

  // Reference model state: is the port held, by whom, and where the next scan starts.
  bit m_locked = 1'b0;
  int m_owner  = 0;
  int m_ptr    = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: compares outputs 1 time unit after each rising edge.
  initial begin
    forever begin
      st_t e;
      fl_t f;
      @(posedge clk);
      #1;
      if (sq.size() > 0) begin
        e = sq.pop_front();
        chk("grt", 64'(grt), 64'(e.grt));
        chk("busy", 64'(busy), 64'(e.busy));
        chk("ovalid", 64'(ovalid), 64'(e.ovalid));
        if (ovalid === 1'b1) begin
          if (fq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL flit_unexpected: got %0h with nothing expected at %0t", odata, $time);
          end else begin
            f = fq.pop_front();
            chk("odata", 64'(odata), 64'(f.dat));
            chk("ovch", 64'(ovch), 64'(f.vch));
          end
        end else begin
          chk("odata_idle", 64'(odata), 64'(0));
          chk("ovch_idle", 64'(ovch), 64'(0));
        end
      end
      if (grt !== '0 && grt_prev === '0) begin
        for (int i = 0; i < NCH; i++) if (grt[i] === 1'b1) g_log.push_back(i);
      end
      grt_prev = grt;
    end
  end

  // Reference model: advance one clock using the inputs now applied; queue expectations.
  task automatic model_eval();
    st_t           e;
    fl_t           f;
    bit            fwd;
    bit            found;
    int            c;
    logic [TW-1:0] t;
    fwd = 1'b0;
    if (rst_) begin
      m_locked = 1'b0;
      m_owner  = 0;
      m_ptr    = 0;
    end else if (m_locked) begin
      if (ivalid[m_owner]) begin
        t = idata[m_owner][TYPE_MSB:TYPE_LSB];
        if (t != TYPE_NONE) begin
          fwd   = 1'b1;
          f.dat = idata[m_owner];
          f.vch = ivch[m_owner];
          fq.push_back(f);
        end
        if (t == TYPE_TAIL || t == TYPE_HEADTAIL) begin
          m_locked = 1'b0;
          m_ptr    = (m_owner + 1) % NCH;
        end
      end
    end else begin
      found = 1'b0;
      for (int k = 0; k < NCH; k++) begin
        c = (m_ptr + k) % NCH;
        if (!found && req[c] && int'(port[c]) == PID) begin
          found    = 1'b1;
          m_locked = 1'b1;
          m_owner  = c;
        end
      end
    end
    e.grt    = m_locked ? NCH'(1 << m_owner) : '0;
    e.busy   = m_locked;
    e.ovalid = fwd;
    sq.push_back(e);
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [DATAW:0] mkflit(logic [TW-1:0] t);
    logic [DATAW:0] d;
    d = $urandom;
    d[TYPE_MSB:TYPE_LSB] = t;
    return d;
  endfunction

  task automatic idle_in();
    req    = '0;
    port   = '0;
    idata  = '0;
    ivalid = '0;
    ivch   = '0;
  endtask

  task automatic want(int ch, int p);
    req[ch]  = 1'b1;
    port[ch] = (PORTW + 1)'(p);
  endtask

  task automatic send(int ch, logic [TW-1:0] t);
    ivalid[ch] = 1'b1;
    idata[ch]  = mkflit(t);
    ivch[ch]   = (VCHW + 1)'($urandom);
  endtask

  task automatic rand_in();
    for (int ch = 0; ch < NCH; ch++) begin
      req[ch]    = ($urandom_range(0, 2) != 0);
      port[ch]   = ($urandom_range(0, 3) == 0) ? (PORTW + 1)'($urandom_range(0, 4))
                                               : (PORTW + 1)'(PID);
      ivalid[ch] = $urandom_range(0, 1) == 1;
      idata[ch]  = mkflit(TW'($urandom_range(0, 4)));
      ivch[ch]   = (VCHW + 1)'($urandom);
    end
  endtask

  task automatic do_reset();
    rst_ = 1'b1;
    idle_in();
    tick();
    rst_ = 1'b0;
  endtask

  int rr_exp[4] = '{0, 1, 3, 0};

  initial begin
    // Reset held for 3 clocks under random inputs.
    rst_ = 1'b1;
    idle_in();
    repeat (3) begin
      rand_in();
      tick();
    end
    rst_ = 1'b0;

    // Single packet HEAD/BODY/TAIL on channel 2.
    idle_in();
    want(2, PID);
    tick();
    tick();
    req[2] = 1'b0;
    send(2, TYPE_HEAD);
    tick();
    send(2, TYPE_BODY);
    tick();
    send(2, TYPE_TAIL);
    tick();
    idle_in();
    tick();
    tick();

    // Round-robin over channels 0, 1, 3 with single-flit packets.
    do_reset();
    g_log.delete();
    want(0, PID);
    want(1, PID);
    want(3, PID);
    repeat (9) begin
      send(0, TYPE_HEADTAIL);
      send(1, TYPE_HEADTAIL);
      send(3, TYPE_HEADTAIL);
      tick();
    end
    idle_in();
    tick();
    tick();
    chk("rr_grant_count_ge4", 64'(g_log.size() >= 4), 64'(1));
    if (g_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("rr_grant_order", 64'(g_log[i]), 64'(rr_exp[i]));
    end

    // Isolation: owner 1 with noise on channels 0 and 4, mismatched request on 3.
    do_reset();
    want(1, PID);
    want(3, (PID + 1) % NCH);
    tick();
    for (int j = 0; j < 4; j++) begin
      send(0, TW'($urandom_range(0, 4)));
      send(4, TW'($urandom_range(0, 4)));
      send(1, (j == 0) ? TYPE_HEAD : (j == 3) ? TYPE_TAIL : TYPE_BODY);
      if (j == 3) req[1] = 1'b0;
      tick();
    end
    ivalid = '0;
    repeat (4) tick();

    // Wrap: owner 4 tail coincides with channel 0 request.
    do_reset();
    want(4, PID);
    tick();
    req[4] = 1'b0;
    send(4, TYPE_HEAD);
    tick();
    send(4, TYPE_TAIL);
    want(0, PID);
    tick();
    ivalid = '0;
    tick();
    tick();
    req[0] = 1'b0;
    send(0, TYPE_HEADTAIL);
    tick();
    idle_in();
    tick();

    // Reset in the middle of a packet, then a fresh grant.
    do_reset();
    want(2, PID);
    tick();
    req[2] = 1'b0;
    send(2, TYPE_HEAD);
    tick();
    send(2, TYPE_BODY);
    rst_ = 1'b1;
    tick();
    rst_ = 1'b0;
    idle_in();
    want(0, PID);
    tick();
    tick();
    req[0] = 1'b0;
    send(0, TYPE_HEADTAIL);
    tick();
    idle_in();
    tick();

    // Random traffic with occasional resets.
    repeat (3000) begin
      rst_ = ($urandom_range(0, 199) == 0);
      rand_in();
      tick();
    end

    rst_ = 1'b0;
    idle_in();
    tick();
    tick();
    chk("flit_queue_drained", 64'(fq.size()), 64'(0));
    chk("status_queue_drained", 64'(sq.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
